// File: rtl/conv_ctrl_if.sv
// conv_ctrl_if: valid/ready stream of one complex sample (re, im).
// master drives valid/re/im and samples ready; slave the reverse.
interface conv_ctrl_if #(
  parameter int W = 18
);
  logic         valid;
  logic         ready;
  logic [W-1:0] re;
  logic [W-1:0] im;

  modport master (
    output valid, re, im,
    input  ready
  );

  modport slave (
    input  valid, re, im,
    output ready
  );
endinterface

// File: rtl/conv_ctrl.sv
// conv_ctrl: one-sample-in-flight sequencer for an ap_ctrl convolver
// with a shadow/active complex coefficient bank pair.
// Ports: clk, resetn (async, active low); coef_wr/addr/re/im write
// the shadow bank; coef_commit requests shadow->active copy
// (commit_pending); s = input sample stream (slave); m = result
// stream (master); conv_start/ready/done + conv_x_*/conv_y_* drive
// the convolver; coef_real/coef_imag = active bank; busy; err.
// Option: CONV_CTRL_WDOG_EN adds a 255-cycle convolver watchdog.
module conv_ctrl #(
  parameter int NTAPS = 32,
  parameter int W     = 18
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       coef_wr,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [W-1:0]               coef_re,
  input  logic [W-1:0]               coef_im,
  input  logic                       coef_commit,
  output logic                       commit_pending,
  conv_ctrl_if.slave                 s,
  conv_ctrl_if.master                m,
  output logic                       conv_start,
  input  logic                       conv_ready,
  input  logic                       conv_done,
  output logic [W-1:0]               conv_x_re,
  output logic [W-1:0]               conv_x_im,
  input  logic [W-1:0]               conv_y_re,
  input  logic [W-1:0]               conv_y_im,
  output logic [NTAPS-1:0][W-1:0]    coef_real,
  output logic [NTAPS-1:0][W-1:0]    coef_imag,
  output logic                       busy,
  output logic                       err
);

  typedef enum logic [2:0] {
    IDLE,
    COPY,
    START,
    WAIT,
    OUT
  } state_t;

  state_t state, nxt;

  logic [NTAPS-1:0][W-1:0] sh_re, sh_im;
  logic [NTAPS-1:0][W-1:0] act_re, act_im;
  logic [W-1:0]            m_re, m_im;

  logic s_rdy;
  logic acc;
  logic cap;
  logic do_copy;
  logic timeout;

`ifdef CONV_CTRL_WDOG_EN
  logic [7:0] wd;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt        = state;
    s_rdy      = 1'b0;
    conv_start = 1'b0;
    acc        = 1'b0;
    cap        = 1'b0;
    do_copy    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit_pending) begin
          nxt = COPY;
        end else begin
          s_rdy = 1'b1;
          if (s.valid) begin
            acc = 1'b1;
            nxt = START;
          end
        end
      end
      COPY: begin
        do_copy = 1'b1;
        nxt     = IDLE;
      end
      START: begin
        conv_start = 1'b1;
        if (conv_ready) begin
          // a same-cycle done skips WAIT entirely
          if (conv_done) begin
            cap = 1'b1;
            nxt = OUT;
          end else begin
            nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (conv_done) begin
          cap = 1'b1;
          nxt = OUT;
        end
      end
      OUT: begin
        if (m.ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
`ifdef CONV_CTRL_WDOG_EN
    // wd==254 marks the 255th cycle spent in START/WAIT
    if ((state == START || state == WAIT) &&
        !cap && wd == 8'hFE) begin
      timeout = 1'b1;
      nxt     = OUT;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      commit_pending <= 1'b0;
      sh_re          <= '0;
      sh_im          <= '0;
      act_re         <= '0;
      act_im         <= '0;
      conv_x_re      <= '0;
      conv_x_im      <= '0;
      m_re           <= '0;
      m_im           <= '0;
    end else begin
      // copy reads the old shadow, so a write in COPY misses it
      if (coef_wr) begin
        sh_re[coef_addr] <= coef_re;
        sh_im[coef_addr] <= coef_im;
      end
      if (do_copy) begin
        act_re <= sh_re;
        act_im <= sh_im;
      end
      if (do_copy)          commit_pending <= 1'b0;
      else if (coef_commit) commit_pending <= 1'b1;
      if (acc) begin
        conv_x_re <= s.re;
        conv_x_im <= s.im;
      end
      if (cap) begin
        m_re <= conv_y_re;
        m_im <= conv_y_im;
      end else if (timeout) begin
        m_re <= '0;
        m_im <= '0;
      end
    end
  end

`ifdef CONV_CTRL_WDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (state == START || state == WAIT) wd <= wd + 8'd1;
      else                                 wd <= '0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign s.ready   = s_rdy;
  assign m.valid   = (state == OUT);
  assign m.re      = m_re;
  assign m.im      = m_im;
  assign busy      = (state != IDLE);
  assign coef_real = act_re;
  assign coef_imag = act_im;

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: directed bench for conv_ctrl with hand-computed
// expectations; drives and samples 1ns after each rising edge.
module tb_conv_ctrl;

  localparam int NTAPS = 32;
  localparam int W     = 18;

  localparam logic [W-1:0] P100 = 18'h00064;
  localparam logic [W-1:0] N50  = 18'h3FFCE;

  logic                    clk;
  logic                    resetn;
  logic                    coef_wr;
  logic [4:0]              coef_addr;
  logic [W-1:0]            coef_re, coef_im;
  logic                    coef_commit;
  logic                    commit_pending;
  logic                    conv_start;
  logic                    conv_ready;
  logic                    conv_done;
  logic [W-1:0]            conv_x_re, conv_x_im;
  logic [W-1:0]            conv_y_re, conv_y_im;
  logic [NTAPS-1:0][W-1:0] coef_real, coef_imag;
  logic                    busy;
  logic                    err;

  int nvec = 0;
  int nerr = 0;

  conv_ctrl_if #(.W(W)) s_if ();
  conv_ctrl_if #(.W(W)) m_if ();

  conv_ctrl #(.NTAPS(NTAPS), .W(W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .coef_wr        (coef_wr),
    .coef_addr      (coef_addr),
    .coef_re        (coef_re),
    .coef_im        (coef_im),
    .coef_commit    (coef_commit),
    .commit_pending (commit_pending),
    .s              (s_if),
    .m              (m_if),
    .conv_start     (conv_start),
    .conv_ready     (conv_ready),
    .conv_done      (conv_done),
    .conv_x_re      (conv_x_re),
    .conv_x_im      (conv_x_im),
    .conv_y_re      (conv_y_re),
    .conv_y_im      (conv_y_im),
    .coef_real      (coef_real),
    .coef_imag      (coef_imag),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [W-1:0] hold_re;
    int n;
    resetn      = 1'b0;
    coef_wr     = 1'b0;
    coef_addr   = '0;
    coef_re     = '0;
    coef_im     = '0;
    coef_commit = 1'b0;
    conv_ready  = 1'b0;
    conv_done   = 1'b0;
    conv_y_re   = '0;
    conv_y_im   = '0;
    s_if.valid  = 1'b0;
    s_if.re     = '0;
    s_if.im     = '0;
    m_if.ready  = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_if.valid, 0);
    chk("rst_start", conv_start, 0);
    chk("rst_pend", commit_pending, 0);
    chk("rst_err", err, 0);
    chk("rst_xre", conv_x_re, 0);
    chk("rst_mre", m_if.re, 0);
    chk("rst_coef0", coef_real[0], 0);
    resetn = 1'b1;
    tick();

    // write shadow[0]=(1,0) with commit in the same cycle
    coef_wr     = 1'b1;
    coef_addr   = 5'd0;
    coef_re     = 18'd1;
    coef_im     = 18'd0;
    coef_commit = 1'b1;
    tick();
    coef_wr     = 1'b0;
    coef_commit = 1'b0;
    chk("c_pend", commit_pending, 1);
    chk("c_act_old", coef_real[0], 0);
    chk("c_sready0", s_if.ready, 0);
    tick();
    chk("copy_busy", busy, 1);
    tick();
    chk("copy_act0", coef_real[0], 1);
    chk("copy_pclr", commit_pending, 0);

    // sample (100,-50); convolver answers 5 cycles after start
    s_if.valid = 1'b1;
    s_if.re    = P100;
    s_if.im    = N50;
    chk("a_sready", s_if.ready, 1);
    tick();
    s_if.valid = 1'b0;
    chk("a_start_c1", conv_start, 1);
    chk("a_xre", conv_x_re, P100);
    chk("a_xim", conv_x_im, N50);
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;
    chk("a_start_drop", conv_start, 0);
    tick();
    tick();
    tick();
    tick();
    conv_done = 1'b1;
    conv_y_re = P100;
    conv_y_im = N50;
    chk("a_mv_pre", m_if.valid, 0);
    tick();
    conv_done = 1'b0;
    chk("a_mvalid", m_if.valid, 1);
    chk("a_mre", m_if.re, P100);
    chk("a_mim", m_if.im, N50);
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;
    chk("a_idle", busy, 0);
    chk("a_mv_clr", m_if.valid, 0);

    // conv_ready low 3 cycles: conv_start high for 4
    s_if.valid = 1'b1;
    s_if.re    = 18'd5;
    s_if.im    = 18'd7;
    tick();
    s_if.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_start%0d", i), conv_start, 1);
      if (i == 3) conv_ready = 1'b1;
      tick();
    end
    conv_ready = 1'b0;
    chk("b_start_off", conv_start, 0);
    conv_done = 1'b1;
    conv_y_re = 18'd11;
    conv_y_im = 18'h3FFFD;
    tick();
    conv_done = 1'b0;
    conv_y_re = '0;
    conv_y_im = '0;

    // m_ready low 10 cycles with a next sample waiting
    s_if.valid = 1'b1;
    s_if.re    = 18'd21;
    s_if.im    = 18'd22;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("o_mv%0d", i), m_if.valid, 1);
      chk($sformatf("o_mre%0d", i), m_if.re, 18'd11);
      chk($sformatf("o_mim%0d", i), m_if.im, 18'h3FFFD);
      chk($sformatf("o_srdy%0d", i), s_if.ready, 0);
      tick();
    end
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;
    chk("o_x_old", conv_x_re, 18'd5);
    chk("o_accept", s_if.ready, 1);
    tick();
    s_if.valid = 1'b0;
    chk("o_x_new", conv_x_re, 18'd21);
    // ready and done together in START go straight to OUT
    conv_ready = 1'b1;
    conv_done  = 1'b1;
    conv_y_re  = 18'd3;
    conv_y_im  = 18'd4;
    tick();
    conv_ready = 1'b0;
    conv_done  = 1'b0;
    chk("d_mvalid", m_if.valid, 1);
    chk("d_mre", m_if.re, 18'd3);
    chk("d_mim", m_if.im, 18'd4);
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;

    // commit during WAIT; late write in COPY stays in shadow
    s_if.valid = 1'b1;
    s_if.re    = 18'd9;
    s_if.im    = 18'd9;
    tick();
    s_if.valid = 1'b0;
    conv_ready = 1'b1;
    tick();
    conv_ready  = 1'b0;
    coef_wr     = 1'b1;
    coef_addr   = 5'd3;
    coef_re     = 18'd30;
    coef_im     = 18'd40;
    coef_commit = 1'b1;
    tick();
    coef_wr     = 1'b0;
    coef_commit = 1'b0;
    chk("w_pend", commit_pending, 1);
    chk("w_act3", coef_real[3], 0);
    conv_done = 1'b1;
    conv_y_re = 18'd1;
    conv_y_im = 18'd1;
    tick();
    conv_done = 1'b0;
    chk("w_out_act3", coef_real[3], 0);
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.re    = 18'd77;
    s_if.im    = 18'd78;
    tick();
    m_if.ready = 1'b0;
    chk("w_idle_srdy", s_if.ready, 0);
    chk("w_idle_act3", coef_real[3], 0);
    tick();
    chk("w_copy_busy", busy, 1);
    chk("w_copy_srdy", s_if.ready, 0);
    coef_wr   = 1'b1;
    coef_addr = 5'd3;
    coef_re   = 18'd99;
    coef_im   = 18'd99;
    tick();
    coef_wr = 1'b0;
    chk("w_act3_re", coef_real[3], 18'd30);
    chk("w_act3_im", coef_imag[3], 18'd40);
    chk("w_pclr", commit_pending, 0);
    chk("w_accept", s_if.ready, 1);
    tick();
    s_if.valid = 1'b0;
    chk("w_x_new", conv_x_re, 18'd77);
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;

    // reset pulsed while in WAIT
    chk("r_busy_pre", busy, 1);
    resetn = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_start", conv_start, 0);
    chk("r_mvalid", m_if.valid, 0);
    chk("r_xre", conv_x_re, 0);
    chk("r_xim", conv_x_im, 0);
    chk("r_mre", m_if.re, 0);
    chk("r_act3", coef_real[3], 0);
    chk("r_act0", coef_real[0], 0);
    tick();
    resetn    = 1'b1;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("r_no_mv", m_if.valid, 0);
    s_if.valid = 1'b1;
    s_if.re    = 18'd8;
    s_if.im    = 18'd9;
    tick();
    s_if.valid = 1'b0;
    chk("r2_start", conv_start, 1);
    chk("r2_xre", conv_x_re, 18'd8);
    conv_ready = 1'b1;
    conv_done  = 1'b1;
    conv_y_re  = 18'd1;
    conv_y_im  = 18'd2;
    tick();
    conv_ready = 1'b0;
    conv_done  = 1'b0;
    chk("r2_mvalid", m_if.valid, 1);
    hold_re = m_if.re;
    chk("r2_mre", hold_re, 18'd1);
    chk("r2_mim", m_if.im, 18'd2);
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;

    // convolver never finishes
    s_if.valid = 1'b1;
    s_if.re    = 18'd5;
    s_if.im    = 18'd5;
    tick();
    s_if.valid = 1'b0;
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;
    n = 2;
`ifdef CONV_CTRL_WDOG_EN
    while (!m_if.valid && n < 400) begin
      tick();
      n++;
    end
    chk("g_cycles", n, 256);
    chk("g_mvalid", m_if.valid, 1);
    chk("g_err", err, 1);
    chk("g_mre", m_if.re, 0);
    chk("g_mim", m_if.im, 0);
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;
    chk("g_err_sticky", err, 1);
`else
    while (n < 300) begin
      tick();
      n++;
    end
    chk("g_busy", busy, 1);
    chk("g_mvalid", m_if.valid, 0);
    chk("g_err", err, 0);
    chk("g_srdy", s_if.ready, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 32, meaning the number of complex coefficient taps.
REQ-002 SHALL have parameter W, default 18, meaning the sample and coefficient width in bits, two's complement.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports coef_wr  input  1, coef_addr  input  $clog2(NTAPS), coef_re / coef_im  input  W  for shadow coefficient bank writes.
REQ-006 SHALL have port coef_commit  input  1  requesting a shadow-to-active bank copy; commit_pending  output  1.
REQ-007 SHALL have ports s_valid  input  1, s_ready  output  1, s_re / s_im  input  W  for the input sample stream.
REQ-008 SHALL have ports m_valid  output  1, m_ready  input  1, m_re / m_im  output  W  for the result stream.
REQ-009 SHALL have ports conv_start  output  1, conv_ready  input  1, conv_done  input  1  as the convolver ap_start / ap_ready / ap_done handshake.
REQ-010 SHALL have ports conv_x_re / conv_x_im  output  W  and conv_y_re / conv_y_im  input  W  for convolver data in and out.
REQ-011 SHALL have ports coef_real / coef_imag  output  [NTAPS][W]  carrying the active bank; busy  output  1; err  output  1.

Function
REQ-012 coef_wr SHALL write {coef_re, coef_im} into shadow[coef_addr] on the next edge in any state; the active bank SHALL change only on commit.
REQ-013 coef_commit SHALL set commit_pending; a repeated commit while pending SHALL have no further effect.
REQ-014 The FSM SHALL have states IDLE, COPY, START, WAIT, OUT.
REQ-015 IDLE: if commit_pending, go to COPY; else s_ready=1, and on s_valid latch s_re/s_im into conv_x_re/conv_x_im and go to START.
REQ-016 COPY: the active bank SHALL take the shadow contents in one cycle; commit_pending SHALL clear; go to IDLE. A coef_wr in the same cycle SHALL land in shadow only.
REQ-017 A coef_wr and a coef_commit in the same IDLE cycle SHALL both take effect, and the write SHALL be included in the copy.
REQ-018 START: conv_start=1 SHALL hold until a cycle with conv_ready=1, then go to WAIT. If conv_done=1 in that same cycle, capture the result and go directly to OUT.
REQ-019 WAIT: on conv_done=1, capture conv_y_re/conv_y_im into m_re/m_im and go to OUT.
REQ-020 OUT: m_valid=1 with m_re/m_im stable until m_ready=1, then go to IDLE.
REQ-021 The accept cycle is cycle 0. conv_start SHALL first rise in cycle 1. m_valid SHALL rise the cycle after conv_done.
REQ-022 s_ready SHALL be 0 in every state except IDLE without commit_pending, so one sample is in flight at most.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 The active bank SHALL never change while conv_start or WAIT is active.

Reset
REQ-025 resetn low SHALL asynchronously force the FSM to IDLE and clear conv_start, m_valid, commit_pending, busy and err, and zero m_re/m_im and conv_x_re/conv_x_im.
REQ-026 On reset, both coefficient banks SHALL clear to zero.
REQ-027 A reset mid-operation SHALL abandon the in-flight sample without emitting m_valid.
REQ-028 Reset deassertion SHALL take effect on the following clk edge.

Configuration
REQ-029 With CONV_CTRL_WDOG_EN defined, an 8-bit counter SHALL run in START and WAIT. At 255 cycles without conv_done, err SHALL set (sticky until reset), the result SHALL be forced to zero, and the FSM SHALL go to OUT.
REQ-030 Without CONV_CTRL_WDOG_EN, the FSM SHALL wait indefinitely, err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-031 Write shadow[0]=(1,0) and commit, then send sample (100,-50) with a convolver model returning (100,-50) 5 cycles after start -> coef_real[0]=1 before conv_start; m_valid with (100,-50); conv_start seen in cycle 1.
REQ-032 conv_ready held low for 3 cycles after start -> conv_start stays high for 4 cycles and drops the cycle after conv_ready.
REQ-033 m_ready held low for 10 cycles in OUT -> m_valid and data stable; s_ready=0 throughout; the next sample is accepted only after the handshake.
REQ-034 coef_commit while in WAIT, then a write to shadow[3] in the COPY cycle -> active bank unchanged until the result handshake; COPY precedes the next accept; active[3] excludes the late write.
REQ-035 resetn pulsed low during WAIT -> all outputs zero immediately; no m_valid; the next sample is processed normally.
REQ-036 With CONV_CTRL_WDOG_EN and conv_done never asserted -> at 255 cycles, err=1, m_valid=1 with (0,0); without the macro, the FSM remains in WAIT and err=0.
